// File: rtl/mem_req_arbiter.sv
// Two-port to one-port memory request arbiter for the LoongArch core.
// The instruction-fetch and data ports share one SRAM-like bus, with at most
// one transaction outstanding. Data requests normally win. A streak counter
// hands the bus to a waiting instruction fetch after MAX_DATA_STREAK
// consecutive contested data grants.
module mem_req_arbiter #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] MAX_STREAK = MAX_DATA_STREAK[3:0];

    state_t      state_r, state_s;
    logic [3:0]  streak_r, streak_s;
    logic        grant_r, grant_s;
    logic        wr_r, wr_s;
    logic [1:0]  size_r, size_s;
    logic [31:0] addr_r, addr_s;
    logic [3:0]  wstrb_r, wstrb_s;
    logic [31:0] wdata_r, wdata_s;
    logic        addr_ok_s;
    logic        data_ok_s;

    // State, streak, owner and latched request fields; synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r  <= IDLE;
            streak_r <= 4'd0;
            grant_r  <= 1'b0;
            wr_r     <= 1'b0;
            size_r   <= 2'd0;
            addr_r   <= 32'd0;
            wstrb_r  <= 4'd0;
            wdata_r  <= 32'd0;
        end else begin
            state_r  <= state_s;
            streak_r <= streak_s;
            grant_r  <= grant_s;
            wr_r     <= wr_s;
            size_r   <= size_s;
            addr_r   <= addr_s;
            wstrb_r  <= wstrb_s;
            wdata_r  <= wdata_s;
        end
    end

    // Next-state logic: arbitrate in IDLE, follow the bus handshake otherwise.
    always_comb begin
        state_s  = state_r;
        streak_s = streak_r;
        grant_s  = grant_r;
        wr_s     = wr_r;
        size_s   = size_r;
        addr_s   = addr_r;
        wstrb_s  = wstrb_r;
        wdata_s  = wdata_r;
        case (state_r)
            IDLE: begin
                if (data_req && (!inst_req || (streak_r < MAX_STREAK))) begin
                    // Data wins; the streak only grows when inst was left waiting.
                    state_s  = REQ;
                    grant_s  = 1'b1;
                    streak_s = inst_req ? (streak_r + 4'd1) : 4'd0;
                    wr_s     = data_wr;
                    size_s   = data_size;
                    addr_s   = data_addr;
                    wstrb_s  = data_wstrb;
                    wdata_s  = data_wdata;
                end else if (inst_req) begin
                    state_s  = REQ;
                    grant_s  = 1'b0;
                    streak_s = 4'd0;
                    wr_s     = inst_wr;
                    size_s   = inst_size;
                    addr_s   = inst_addr;
                    wstrb_s  = inst_wstrb;
                    wdata_s  = inst_wdata;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (mem_addr_ok && mem_data_ok) begin
                    state_s = IDLE;
                end else if (mem_addr_ok) begin
                    state_s = RESP;
                end else begin
                    state_s = REQ;
                end
            end
            RESP: begin
                if (mem_data_ok) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Zero-latency handshake steering back to the owning port only; a
    // response seen during reset or in IDLE belongs to nobody.
    always_comb begin
        addr_ok_s = 1'b0;
        data_ok_s = 1'b0;
        if (resetn && (state_r == REQ)) begin
            addr_ok_s = mem_addr_ok;
            data_ok_s = mem_addr_ok && mem_data_ok;
        end else if (resetn && (state_r == RESP)) begin
            data_ok_s = mem_data_ok;
        end else begin
            addr_ok_s = 1'b0;
            data_ok_s = 1'b0;
        end
        inst_addr_ok = addr_ok_s && !grant_r;
        inst_data_ok = data_ok_s && !grant_r;
        data_addr_ok = addr_ok_s && grant_r;
        data_data_ok = data_ok_s && grant_r;
        inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
        data_rdata   = data_data_ok ? mem_rdata : 32'd0;
    end

    assign mem_req   = (state_r == REQ);
    assign mem_wr    = wr_r;
    assign mem_size  = size_r;
    assign mem_addr  = addr_r;
    assign mem_wstrb = wstrb_r;
    assign mem_wdata = wdata_r;
    assign busy      = (state_r != IDLE);
    assign grant_id  = grant_r;

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one SRAM-like memory bus between the IF-stage instruction port and the EX/MEM-stage data port of the LoongArch pipeline.
- Sits between the CPU core and the memory bridge.
- Keeps at most one transaction outstanding.
- Data requests have priority. A streak counter stops the instruction port from starving.

Parameters:
- MAX_DATA_STREAK, 4: consecutive data grants allowed while inst_req is pending before inst is forced to win. Range 1..15.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- inst_req  in  1  instruction request, held until inst_addr_ok
- inst_wr  in  1  write enable (0 for fetch)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  32  byte address
- inst_wstrb  in  4  byte strobes
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  request accepted
- inst_data_ok  out  1  response valid
- inst_rdata  out  32  read data
- data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  1/1/2/32/4/32  data port, same meanings as inst_*
- data_addr_ok, data_data_ok, data_rdata  out  1/1/32  data port, same meanings as inst_*
- mem_req  out  1  downstream request
- mem_wr  out  1  downstream write enable
- mem_size  out  2  downstream size
- mem_addr  out  32  downstream address
- mem_wstrb  out  4  downstream byte strobes
- mem_wdata  out  32  downstream write data
- mem_addr_ok  in  1  downstream accepted the request
- mem_data_ok  in  1  downstream response valid
- mem_rdata  in  32  downstream read data
- busy  out  1  state != IDLE
- grant_id  out  1  owner of the current transaction: 0=inst, 1=data

Behaviour:
- Reset (resetn=0 at posedge clk):
  - state=IDLE, streak=0, grant_id=0.
  - All mem_* request fields are 0.
  - All *_addr_ok, *_data_ok and *_rdata outputs are 0.
  - Reset mid-transaction abandons the transaction. No data_ok is issued afterwards.
  - A mem_data_ok arriving while in IDLE is ignored.
- FSM, three states:
  - IDLE:
    - No request: stay in IDLE.
    - At least one request: arbitrate, register the winner's wr/size/addr/wstrb/wdata into the mem_* registers, set grant_id, go to REQ.
  - REQ:
    - mem_req=1, and the mem_* fields are held stable.
    - mem_addr_ok=1 and mem_data_ok=0: pulse the granted port's *_addr_ok in the same cycle (combinational from mem_addr_ok), go to RESP.
    - mem_addr_ok=1 and mem_data_ok=1 in the same cycle: pulse both *_addr_ok and *_data_ok of the granted port, go to IDLE.
    - Otherwise stay in REQ.
  - RESP:
    - mem_req=0.
    - On mem_data_ok: granted *_data_ok=1 and *_rdata=mem_rdata in the same cycle, go to IDLE.
- Latency:
  - 1 cycle from an IDLE requester's req to mem_req.
  - 0 cycles from mem_addr_ok/mem_data_ok to the corresponding requester pulse.
  - Back-to-back minimum: a transaction completing (response) in cycle N lets the next request be granted in cycle N+1 and drive mem_req in N+2.
- Non-granted port: *_addr_ok=0 and *_data_ok=0 at all times. *_rdata=0 whenever its *_data_ok=0.
- Arbitration, evaluated in IDLE only:
  - Only one requester: it wins.
  - Both requesting and streak < MAX_DATA_STREAK: data wins, streak+1.
  - Both requesting and streak == MAX_DATA_STREAK: inst wins, streak=0.
  - Inst wins for any reason: streak=0.
  - Data wins while inst_req=0: streak=0.
- Streak counter: 4 bits, saturates at MAX_DATA_STREAK, never wraps.
- Requester fields are sampled only at grant. Changes afterwards have no effect.
- The same request is never granted twice. The requester drops req on addr_ok, and the arbiter is out of IDLE until the transaction finishes.
- busy=1 in REQ and RESP.

Test Plan:
- Single inst read: inst_req with addr=0x1C000000, size=2. mem_addr_ok arrives 2 cycles after mem_req, mem_data_ok with mem_rdata=0x02800000 the cycle after that.
  -> mem_req asserted exactly 1 cycle after inst_req.
  -> inst_addr_ok pulses once; inst_data_ok pulses once with inst_rdata=0x02800000.
  -> data_* outputs stay 0 throughout.
- Simultaneous requests: inst_req and data_req (write, addr=0x1000, wstrb=4'b0011, wdata=0xDEADBEEF) asserted together.
  -> Data wins: mem_wr=1, mem_addr=0x1000, mem_wstrb=0011.
  -> Inst is granted in the IDLE cycle right after the data response.
- Starvation guard, MAX_DATA_STREAK=4: inst_req held high while data_req is continuously reasserted.
  -> Grant sequence is D,D,D,D,I,D,...
- Same-cycle handshake: mem_addr_ok=1 and mem_data_ok=1 in one REQ cycle, mem_rdata=0x12345678.
  -> data_addr_ok and data_data_ok pulse in the same cycle, data_rdata=0x12345678.
  -> State returns to IDLE and busy=0 next cycle.
- Reset mid-RESP: resetn=0 for one cycle while in RESP, then mem_data_ok arrives afterwards.
  -> No *_data_ok pulse, busy=0, streak=0, mem_req=0.
- Field stability: requester changes addr while in REQ with mem_addr_ok withheld for 5 cycles.
  -> mem_addr keeps the value sampled at grant for all 5 cycles.
